// File: rtl/mult_div_iter_if.sv
// Request/result bundle for the iterative multiply/divide unit.
// The master drives the operation request; the slave returns HI/LO and status.
interface mult_div_iter_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             done;
    logic             div0;

    modport master (
        output start, op, a, b, cancel,
        input  busy, hi, lo, done, div0
    );

    modport slave (
        input  start, op, a, b, cancel,
        output busy, hi, lo, done, div0
    );
endinterface

// File: rtl/mult_div_iter.sv
// Iterative MIPS-style HI/LO unit: one bit per cycle shift-add multiply and
// restoring divide on magnitudes, with the sign fix-up applied in a final FIX cycle.
module mult_div_iter #(
    parameter int WIDTH = 32
) (
    input logic            clk,
    input logic            reset,
    mult_div_iter_if.slave bus
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_MADD  = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t             state_r;
    logic [CW-1:0]      count_r;
    logic [2:0]         op_r;
    logic [WIDTH:0]     acc_hi_r;
    logic [WIDTH-1:0]   acc_lo_r;
    logic [WIDTH-1:0]   mcand_r;
    logic               neg_q_r;
    logic               neg_r_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               busy_r;
    logic               done_r;
    logic               div0_r;

    logic               signed_op_s;
    logic               a_neg_s;
    logic               b_neg_s;
    logic [WIDTH-1:0]   abs_a_s;
    logic [WIDTH-1:0]   abs_b_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     div_shift_s;
    logic [WIDTH:0]     div_trial_s;
    logic [WIDTH:0]     step_hi_s;
    logic [WIDTH-1:0]   step_lo_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_signed_s;
    logic [2*WIDTH-1:0] madd_s;
    logic [WIDTH-1:0]   quot_s;
    logic [WIDTH-1:0]   rem_s;

    assign bus.busy = busy_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
    assign bus.done = done_r;
    assign bus.div0 = div0_r;

    // Operand magnitudes and sign flags captured when an operation launches.
    always_comb begin
        signed_op_s = (bus.op == OP_MULT) || (bus.op == OP_DIV) || (bus.op == OP_MADD);
        a_neg_s     = signed_op_s && bus.a[WIDTH-1];
        b_neg_s     = signed_op_s && bus.b[WIDTH-1];
        if (a_neg_s) begin
            abs_a_s = {WIDTH{1'b0}} - bus.a;
        end else begin
            abs_a_s = bus.a;
        end
        if (b_neg_s) begin
            abs_b_s = {WIDTH{1'b0}} - bus.b;
        end else begin
            abs_b_s = bus.b;
        end
    end

    // One iteration: acc_hi holds partial product / remainder, acc_lo the multiplier / quotient.
    always_comb begin
        if (acc_lo_r[0]) begin
            mul_sum_s = acc_hi_r + {1'b0, mcand_r};
        end else begin
            mul_sum_s = acc_hi_r;
        end
        div_shift_s = {acc_hi_r[WIDTH-1:0], acc_lo_r[WIDTH-1]};
        div_trial_s = div_shift_s - {1'b0, mcand_r};
        if ((op_r == OP_DIV) || (op_r == OP_DIVU)) begin
            if (!div_trial_s[WIDTH]) begin
                step_hi_s = div_trial_s;
                step_lo_s = {acc_lo_r[WIDTH-2:0], 1'b1};
            end else begin
                step_hi_s = div_shift_s;
                step_lo_s = {acc_lo_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_hi_s = {1'b0, mul_sum_s[WIDTH:1]};
            step_lo_s = {mul_sum_s[0], acc_lo_r[WIDTH-1:1]};
        end
    end

    // Sign correction of the magnitude results; overflow of MIN/-1 falls out naturally.
    always_comb begin
        prod_s = {acc_hi_r[WIDTH-1:0], acc_lo_r};
        if (neg_q_r) begin
            prod_signed_s = {(2*WIDTH){1'b0}} - prod_s;
            quot_s        = {WIDTH{1'b0}} - acc_lo_r;
        end else begin
            prod_signed_s = prod_s;
            quot_s        = acc_lo_r;
        end
        if (neg_r_r) begin
            rem_s = {WIDTH{1'b0}} - acc_hi_r[WIDTH-1:0];
        end else begin
            rem_s = acc_hi_r[WIDTH-1:0];
        end
        madd_s = {hi_r, lo_r} + prod_signed_s;
    end

    // Control FSM, datapath registers and architectural HI/LO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= IDLE;
            count_r  <= {CW{1'b0}};
            op_r     <= 3'd0;
            acc_hi_r <= {(WIDTH+1){1'b0}};
            acc_lo_r <= {WIDTH{1'b0}};
            mcand_r  <= {WIDTH{1'b0}};
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            hi_r     <= {WIDTH{1'b0}};
            lo_r     <= {WIDTH{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            div0_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            div0_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.start && !bus.cancel) begin
                        case (bus.op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD: begin
                                op_r     <= bus.op;
                                acc_hi_r <= {(WIDTH+1){1'b0}};
                                acc_lo_r <= abs_a_s;
                                mcand_r  <= abs_b_s;
                                neg_q_r  <= a_neg_s ^ b_neg_s;
                                neg_r_r  <= a_neg_s;
                                count_r  <= CW'(WIDTH);
                                state_r  <= CALC;
                                busy_r   <= 1'b1;
                            end
                            OP_MTHI: hi_r <= bus.a;
                            OP_MTLO: lo_r <= bus.a;
                            default: begin
                            end
                        endcase
                    end
                end
                CALC: begin
                    if (bus.cancel) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        count_r <= {CW{1'b0}};
                    end else begin
                        acc_hi_r <= step_hi_s;
                        acc_lo_r <= step_lo_s;
                        count_r  <= count_r - CW'(1);
                        if (count_r == CW'(1)) begin
                            state_r <= FIX;
                        end else begin
                            state_r <= CALC;
                        end
                    end
                end
                FIX: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    if (!bus.cancel) begin
                        case (op_r)
                            OP_MULT, OP_MULTU: begin
                                {hi_r, lo_r} <= prod_signed_s;
                                done_r       <= 1'b1;
                            end
                            OP_MADD: begin
                                {hi_r, lo_r} <= madd_s;
                                done_r       <= 1'b1;
                            end
                            OP_DIV, OP_DIVU: begin
                                if (mcand_r == {WIDTH{1'b0}}) begin
                                    div0_r <= 1'b1;
                                end else begin
                                    hi_r   <= rem_s;
                                    lo_r   <= quot_s;
                                    done_r <= 1'b1;
                                end
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    count_r <= {CW{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: doc/mult_div_iter.md
MULT_DIV_ITER -- requirements
Module: mult_div_iter

Interface
REQ-001 Parameter WIDTH, default 32, sets the operand and HI/LO width; legal values are 8 to 64 in steps of 8.
REQ-002 clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  launches the operation on op when sampled high while idle.
REQ-005 op  input  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 MADD (signed HI:LO += a*b).
REQ-006 a, b  input  WIDTH  operands; a is the dividend for DIV/DIVU and the source for MTHI/MTLO.
REQ-007 cancel  input  1  exception/interrupt kill; aborts the in-flight operation.
REQ-008 busy  output  1  registered; high while an operation is in flight.
REQ-009 hi, lo  output  WIDTH  architectural HI and LO registers.
REQ-010 done  output  1  one-cycle pulse when HI/LO update from a completed MULT/MULTU/DIV/DIVU/MADD.
REQ-011 div0  output  1  one-cycle pulse when a DIV/DIVU with b==0 completes.

Function
REQ-012 The FSM SHALL have three states: IDLE, CALC and FIX; busy SHALL be high when the state is not IDLE.
REQ-013 In IDLE, start with op in {001,010,011,100,111} and cancel low SHALL latch the operands (magnitudes and result-sign bits for signed ops), load count=WIDTH and enter CALC.
REQ-014 CALC SHALL process one bit per cycle: shift-add for multiply, restoring subtract-shift for divide, for exactly WIDTH cycles, then enter FIX.
REQ-015 FIX SHALL apply the sign correction, write HI/LO, pulse done, and return to IDLE; busy SHALL be high for exactly WIDTH+1 cycles per operation.
REQ-016 HI/LO SHALL hold their previous values until the FIX edge, and SHALL be readable with new values on the first cycle busy is low.
REQ-017 MULT/MULTU SHALL set {hi,lo} to the full 2*WIDTH-bit product; MADD SHALL set {hi,lo} = {hi,lo} + signed product, modulo 2^(2*WIDTH).
REQ-018 DIV/DIVU SHALL set lo=quotient and hi=remainder; signed quotients truncate toward zero and the remainder takes the sign of the dividend.
REQ-019 Signed overflow (most-negative / -1) SHALL give lo = most-negative value and hi = 0.
REQ-020 For a divide with b==0, hi/lo SHALL be unchanged, div0 SHALL pulse in FIX and done SHALL stay low; the latency is unchanged.
REQ-021 MTHI/MTLO in IDLE with start high and cancel low SHALL write a to hi/lo on the same edge, SHALL leave busy low, and SHALL not pulse done.
REQ-022 start while busy SHALL be ignored; the caller stalls on start|busy.
REQ-023 cancel high in CALC or FIX SHALL force IDLE on the next edge with hi/lo unchanged and done/div0 low.
REQ-024 cancel and start both high in IDLE: cancel SHALL win and nothing executes, including MTHI/MTLO.
REQ-025 op=000 with start high SHALL be a no-op.

Reset
REQ-026 reset low SHALL immediately force IDLE with busy=0, hi=0, lo=0, done=0, div0=0 and count=0, including during CALC or FIX.
REQ-027 After reset deasserts, the first start SHALL be accepted on the next rising edge.

Verification (WIDTH=32)
REQ-028 MULT a=FFFFFFFF, b=00000003 -> busy high 33 cycles, then hi=FFFFFFFF, lo=FFFFFFFD, one done pulse.
REQ-029 MULTU a=FFFFFFFF, b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001; a following MADD a=2, b=3 -> hi=FFFFFFFE, lo=00000007.
REQ-030 DIV a=FFFFFFF9 (-7), b=2 -> lo=FFFFFFFD, hi=FFFFFFFF; DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=0.
REQ-031 With hi=11111111 and lo=22222222, DIVU a=7, b=0 -> div0 pulses after 33 cycles, done=0, hi/lo unchanged.
REQ-032 MULT started, cancel asserted in CALC cycle 10 -> busy=0 next cycle and hi/lo retain their prior values; a start asserted together with cancel -> ignored.
REQ-033 reset pulled low mid-CALC and asynchronously between edges -> all outputs 0 immediately; MTLO a=12345678 right after release -> lo=12345678 with busy never high.
